// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit for the EX stage.
// Multiplies run LSB-first shift-add, divides run MSB-first restoring subtract,
// one step per cycle on magnitudes, with sign correction applied in FIN.
// Optional build macro MULDIV_EARLY_OUT_EN: trivial ops (divide by zero,
// multiply by zero) skip CALC and go straight to FIN.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy,
  output logic            stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_f3;
  logic [XLEN-1:0]     r_x;        // multiplier (shifts right) or dividend (shifts left)
  logic [XLEN-1:0]     r_y;        // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   r_acc;      // product, or {remainder, quotient}
  logic [XLEN-1:0]     r_raw_a;
  logic                r_neg;
  logic                r_dbz;

  // ---------------------------------------------------------------------
  // Operand decode on the incoming request
  // ---------------------------------------------------------------------
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_neg;
  logic            w_dbz;

  assign w_is_div   = funct3[2];
  // MULH/MULHSU sign op_a, MULH signs op_b; DIV/REM sign both
  assign w_a_signed = w_is_div ? ~funct3[0]
                               : (funct3[1:0] == 2'b01) | (funct3[1:0] == 2'b10);
  assign w_b_signed = w_is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign w_a_neg    = w_a_signed & op_a[XLEN-1];
  assign w_b_neg    = w_b_signed & op_b[XLEN-1];
  assign w_abs_a    = w_a_neg ? -op_a : op_a;
  assign w_abs_b    = w_b_neg ? -op_b : op_b;
  // remainder takes the dividend's sign; product and quotient take the xor
  assign w_neg      = (w_is_div & funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_dbz      = w_is_div & (op_b == '0);

`ifdef MULDIV_EARLY_OUT_EN
  logic w_early;
  assign w_early = w_dbz | (~w_is_div & ((op_a == '0) | (op_b == '0)));
`endif

  // ---------------------------------------------------------------------
  // One iteration of each datapath
  // ---------------------------------------------------------------------
  logic [XLEN-1:0]   w_addend;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_diff;
  logic [XLEN-1:0]   w_rem_new;
  logic [2*XLEN-1:0] w_div_next;

  assign w_addend   = r_x[0] ? r_y : '0;
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // partial remainder stays below the divisor, so XLEN bits hold the difference
  assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_x[XLEN-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_y});
  assign w_rem_diff = w_rem_sh[XLEN-1:0] - r_y;
  assign w_rem_new  = w_ge ? w_rem_diff : w_rem_sh[XLEN-1:0];
  assign w_div_next = {w_rem_new, r_acc[XLEN-2:0], w_ge};

  // ---------------------------------------------------------------------
  // Final result selection with sign correction and divide-by-zero override
  // ---------------------------------------------------------------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fin;

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  // pick the word the op asks for
  always_comb begin
    w_fin = '0;
    case (r_f3)
      3'b000:                 w_fin = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fin = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fin = r_dbz ? '1 : w_quo;
      default:                w_fin = r_dbz ? r_raw_a : w_rem;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control outputs
  // ---------------------------------------------------------------------
  assign busy  = (r_state != S_IDLE);
  assign stall = ((r_state == S_IDLE) & start & ~flush) | (r_state == S_CALC);

  // sequencer FSM with datapath registers and registered result/done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_f3    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_acc   <= '0;
      r_raw_a <= '0;
      r_neg   <= 1'b0;
      r_dbz   <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_f3    <= funct3;
              r_raw_a <= op_a;
              r_neg   <= w_neg;
              r_dbz   <= w_dbz;
              r_acc   <= '0;
              r_cnt   <= '0;
              if (w_is_div) begin
                r_x <= w_abs_a;
                r_y <= w_abs_b;
              end else begin
                r_x <= w_abs_b;
                r_y <= w_abs_a;
              end
`ifdef MULDIV_EARLY_OUT_EN
              r_state <= w_early ? S_FIN : S_CALC;
`else
              r_state <= S_CALC;
`endif
            end
          end
          S_CALC: begin
            if (r_f3[2]) begin
              r_acc <= w_div_next;
              r_x   <= r_x << 1;
            end else begin
              r_acc <= w_mul_next;
              r_x   <= r_x >> 1;
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) begin
              r_state <= S_FIN;
            end
          end
          S_FIN: begin
            result  <= w_fin;
            done    <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed RV32M cases, randomized
// back-to-back ops against an arithmetic reference model, flush and reset.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        stall;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_last;

  muldiv_sequencer #(.XLEN(32), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .result (result),
    .done   (done),
    .busy   (busy),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  // Reference model: RV32M semantics from 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    logic [63:0] ua64;
    logic [63:0] ub64;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'b0, b});
    ua64 = {32'b0, a};
    ub64 = {32'b0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua64 * ub64; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Edges from start acceptance until done is visible
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if ((f[2] && b == 32'd0) || (!f[2] && (a == 32'd0 || b == 32'd0))) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op (call just after a negedge) and check result, latency, stall.
  // Returns just after the negedge where done is seen, so calls chain back-to-back.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit hold);
    int lat_exp;
    int st_cnt;
    int cyc;
    bit seen;
    lat_exp = exp_lat(f, a, b);
    st_cnt  = 0;
    cyc     = 0;
    seen    = 1'b0;
    start   = 1'b1;
    funct3  = f;
    op_a    = a;
    op_b    = b;
    #1;
    if (stall === 1'b1) st_cnt++;
    @(posedge clk);
    #1;
    start  = hold;
    op_a   = $urandom;
    op_b   = $urandom;
    funct3 = 3'($urandom);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      cyc = k;
      if (k == 1) begin
        n_vec++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
        end
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (stall === 1'b1) st_cnt++;
      start = hold && (k + 1 < lat_exp);
      op_a  = $urandom;
      op_b  = $urandom;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s timeout: done not seen within 100 cycles, want latency %0d", name, lat_exp);
      start = 1'b0;
    end else begin
      n_vec++;
      if (result !== exp) begin
        n_err++;
        $display("FAIL %s result: got %h want %h (f3=%0d a=%h b=%h)", name, result, exp, f, a, b);
      end
      n_vec++;
      if (cyc - 1 != lat_exp) begin
        n_err++;
        $display("FAIL %s latency: got %0d want %0d", name, cyc - 1, lat_exp);
      end
      n_vec++;
      if (st_cnt != lat_exp) begin
        n_err++;
        $display("FAIL %s stall_cycles: got %0d want %0d", name, st_cnt, lat_exp);
      end
      n_vec++;
      if ({busy, stall} !== 2'b00) begin
        n_err++;
        $display("FAIL %s busy_stall_at_done: got %b want 00", name, {busy, stall});
      end
      exp_last = exp;
      start    = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'd0;
    op_a   = 32'd0;
    op_b   = 32'd0;
    #1 rst_n = 1'b0;
    #3;
    n_vec++;
    if ({result, done, busy, stall} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got result=%h done=%b busy=%b stall=%b want all 0", result, done, busy, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({result, done, busy, stall} !== 35'd0) begin
      n_err++;
      $display("FAIL idle_after_reset: got result=%h done=%b busy=%b stall=%b want all 0", result, done, busy, stall);
    end
    exp_last = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op("mul_7x6",         3'd0, 32'd7,          32'd6,          32'd42,         1'b0);
    run_op("mulh_min_min",    3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  1'b0);
    run_op("mulhu_min_min",   3'd3, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  1'b0);
    run_op("mulhsu_m1_2",     3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  1'b0);
    run_op("div_m7_2",        3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0);
    run_op("rem_m7_2",        3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0);
    run_op("div_overflow",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0);
    run_op("rem_overflow",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0);
    run_op("divu_by_zero",    3'd5, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1'b0);
    run_op("rem_by_zero",     3'd6, 32'hFFFF_FF00,  32'd0,          32'hFFFF_FF00,  1'b0);
    run_op("div_by_zero",     3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b0);
    run_op("mul_zero",        3'd0, 32'd0,          32'h1234,       32'd0,          1'b1);
    run_op("remu_100_7",      3'd7, 32'd100,        32'd7,          32'd2,          1'b1);
  endtask

  // Consecutive run_op calls issue each start in the done cycle of the last op
  task automatic test_back_to_back();
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = rand_op();
      b = rand_op();
      run_op("random", f, a, b, model(f, a, b), 1'($urandom));
    end
  endtask

  task automatic test_flush_calc();
    logic [31:0] held;
    int          pulses;
    held   = exp_last;
    start  = 1'b1;
    funct3 = 3'd5;
    op_a   = 32'd12345;
    op_b   = 32'd17;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({busy, stall, done} !== 3'b000) begin
      n_err++;
      $display("FAIL flush_calc_ctrl: got busy/stall/done=%b want 000", {busy, stall, done});
    end
    n_vec++;
    if (result !== held) begin
      n_err++;
      $display("FAIL flush_calc_hold: got %h want %h", result, held);
    end
    flush  = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL flush_calc_no_done: got %0d pulses want 0", pulses);
    end
    run_op("divu_after_flush", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
  endtask

  task automatic test_flush_fin();
    logic [31:0] held;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    held   = exp_last;
    a      = $urandom | 32'd1;
    b      = $urandom | 32'd1;
    lat    = exp_lat(3'd3, a, b);
    start  = 1'b1;
    funct3 = 3'd3;
    op_a   = a;
    op_b   = b;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (lat) @(negedge clk);
    n_vec++;
    if ({busy, stall, done} !== 3'b100) begin
      n_err++;
      $display("FAIL fin_state_ctrl: got busy/stall/done=%b want 100", {busy, stall, done});
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_fin_ctrl: got busy/done=%b want 00", {busy, done});
    end
    n_vec++;
    if (result !== held) begin
      n_err++;
      $display("FAIL flush_fin_hold: got %h want %h", result, held);
    end
    flush = 1'b0;
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL flush_fin_no_done: got %b want 0", done);
    end
  endtask

  task automatic test_async_reset();
    start  = 1'b1;
    funct3 = 3'd0;
    op_a   = 32'd99;
    op_b   = 32'd101;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({result, done, busy, stall} !== 35'd0) begin
      n_err++;
      $display("FAIL async_reset: got result=%h done=%b busy=%b stall=%b want all 0", result, done, busy, stall);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    exp_last = 32'd0;
    @(negedge clk);
    run_op("remu_after_reset", 3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush_calc();
    test_flush_fin();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
